// File: rtl/xdata_reader_pkg.sv
// Shared definitions for the MOVX external data read sequencer:
// bus-cycle state encodings, port reset value and the timer width helper.
package xdata_reader_pkg;

  typedef enum logic [2:0] {
    XRD_IDLE = 3'd0,
    XRD_ADDR = 3'd1,
    XRD_HOLD = 3'd2,
    XRD_READ = 3'd3,
    XRD_DONE = 3'd4
  } xrd_state_e;

  localparam logic [7:0] PORT_RST = 8'hFF;

  function automatic int cnt_width(
    input int a,
    input int b
  );
    return $clog2(((a > b) ? a : b) + 1);
  endfunction

endpackage

// File: rtl/xdata_reader_xbus_timer.sv
// xbus_timer: loadable saturating down-counter, tc_o high at zero.
// Times the ALE and RD_n phases of the external bus cycle.
module xbus_timer #(
  parameter int W = 2
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         load_i,
  input  logic [W-1:0] load_val_i,
  output logic         tc_o
);

  logic [W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = load_val_i;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc_o = (cnt_q == '0);

endmodule

// File: rtl/xdata_reader.sv
// xdata_reader: MOVX external data-memory read sequencer on the P0/P2 bus.
// Define XDATA_WAIT_EN to add ext_wait, which stretches RD_n at terminal count.
module xdata_reader
  import xdata_reader_pkg::*;
#(
  parameter int ADDR_CYCLES = 1,
  parameter int RD_CYCLES   = 3
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       rd_req,
  input  logic       use_ri,
  input  logic [7:0] ri_addr,
  input  logic [7:0] dptr_h,
  input  logic [7:0] dptr_l,
  input  logic [7:0] p2_sfr,
  input  logic [7:0] p0_in,
`ifdef XDATA_WAIT_EN
  input  logic       ext_wait,
`endif
  output logic [7:0] p0_out,
  output logic       p0_oe,
  output logic [7:0] p2_out,
  output logic       ale,
  output logic       rd_n,
  output logic [7:0] data_out,
  output logic       busy,
  output logic       done
);

  localparam int CW = cnt_width(ADDR_CYCLES, RD_CYCLES);
  localparam logic [CW-1:0] ADDR_LD = CW'(ADDR_CYCLES - 1);
  localparam logic [CW-1:0] READ_LD = CW'(RD_CYCLES - 1);

  xrd_state_e state_q, state_d;
  logic [7:0] hi_q, hi_d, lo_q, lo_d;
  logic [7:0] data_q, data_d;
  logic [7:0] p0_out_q, p0_out_d;
  logic [7:0] p2_out_q, p2_out_d;
  logic p0_oe_q, p0_oe_d;
  logic ale_q, ale_d;
  logic rd_n_q, rd_n_d;
  logic busy_q, busy_d;
  logic done_q, done_d;
  logic tmr_ld, tmr_tc, wait_w;
  logic [CW-1:0] tmr_val;

`ifdef XDATA_WAIT_EN
  assign wait_w = ext_wait;
`else
  assign wait_w = 1'b0;
`endif

  xbus_timer #(
    .W(CW)
  ) u_timer (
    .clock      (clock),
    .reset      (reset),
    .load_i     (tmr_ld),
    .load_val_i (tmr_val),
    .tc_o       (tmr_tc)
  );

  always_comb begin
    state_d = state_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    data_d  = data_q;
    unique case (state_q)
      XRD_IDLE: begin
        if (rd_req) begin
          state_d = XRD_ADDR;
          hi_d    = use_ri ? p2_sfr : dptr_h;
          lo_d    = use_ri ? ri_addr : dptr_l;
        end
      end
      XRD_ADDR: if (tmr_tc) state_d = XRD_HOLD;
      XRD_HOLD: state_d = XRD_READ;
      XRD_READ: begin
        if (tmr_tc && !wait_w) begin
          state_d = XRD_DONE;
          data_d  = p0_in;
        end
      end
      XRD_DONE: state_d = XRD_IDLE;
      default:  state_d = XRD_IDLE;
    endcase
  end

  // Timer reloads on every state entry; a wait hold keeps it parked at zero.
  always_comb begin
    tmr_ld  = (state_d != state_q);
    tmr_val = '0;
    if (state_d == XRD_ADDR) tmr_val = ADDR_LD;
    if (state_d == XRD_READ) tmr_val = READ_LD;
  end

  // Pad outputs are decoded from the next state so they register cleanly.
  always_comb begin
    p0_out_d = PORT_RST;
    p2_out_d = p2_sfr;
    p0_oe_d  = 1'b0;
    ale_d    = 1'b0;
    rd_n_d   = 1'b1;
    busy_d   = 1'b1;
    done_d   = 1'b0;
    unique case (state_d)
      XRD_ADDR: begin
        ale_d    = 1'b1;
        p0_oe_d  = 1'b1;
        p0_out_d = lo_d;
        p2_out_d = hi_d;
      end
      XRD_HOLD: begin
        p0_oe_d  = 1'b1;
        p0_out_d = lo_d;
        p2_out_d = hi_d;
      end
      XRD_READ: begin
        rd_n_d   = 1'b0;
        p2_out_d = hi_d;
      end
      XRD_DONE: done_d = 1'b1;
      default:  busy_d = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q  <= XRD_IDLE;
      hi_q     <= '0;
      lo_q     <= '0;
      data_q   <= 8'h00;
      p0_out_q <= PORT_RST;
      p2_out_q <= PORT_RST;
      p0_oe_q  <= 1'b0;
      ale_q    <= 1'b0;
      rd_n_q   <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      data_q   <= data_d;
      p0_out_q <= p0_out_d;
      p2_out_q <= p2_out_d;
      p0_oe_q  <= p0_oe_d;
      ale_q    <= ale_d;
      rd_n_q   <= rd_n_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
    end
  end

  assign p0_out   = p0_out_q;
  assign p0_oe    = p0_oe_q;
  assign p2_out   = p2_out_q;
  assign ale      = ale_q;
  assign rd_n     = rd_n_q;
  assign data_out = data_q;
  assign busy     = busy_q;
  assign done     = done_q;

endmodule

// File: tb/tb_xdata_reader.sv
// Scoreboard bench for xdata_reader: a cycle-arithmetic model of each
// accepted read feeds a queue that a posedge monitor checks against the pads.
module tb_xdata_reader;

  localparam int A = 1;
  localparam int R = 3;
`ifdef XDATA_WAIT_EN
  localparam bit WAIT_EN = 1'b1;
`else
  localparam bit WAIT_EN = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic       rd_req = 1'b0;
  logic       use_ri = 1'b0;
  logic [7:0] ri_addr = '0;
  logic [7:0] dptr_h = '0;
  logic [7:0] dptr_l = '0;
  logic [7:0] p2_sfr = '0;
  logic [7:0] p0_in = '0;
`ifdef XDATA_WAIT_EN
  logic       ext_wait = 1'b0;
`endif
  logic [7:0] p0_out, p2_out, data_out;
  logic       p0_oe, ale, rd_n, busy, done;

  xdata_reader #(
    .ADDR_CYCLES(A),
    .RD_CYCLES  (R)
  ) dut (
    .clock    (clock),
    .reset    (reset),
    .rd_req   (rd_req),
    .use_ri   (use_ri),
    .ri_addr  (ri_addr),
    .dptr_h   (dptr_h),
    .dptr_l   (dptr_l),
    .p2_sfr   (p2_sfr),
    .p0_in    (p0_in),
`ifdef XDATA_WAIT_EN
    .ext_wait (ext_wait),
`endif
    .p0_out   (p0_out),
    .p0_oe    (p0_oe),
    .p2_out   (p2_out),
    .ale      (ale),
    .rd_n     (rd_n),
    .data_out (data_out),
    .busy     (busy),
    .done     (done)
  );

  always #5 clock = ~clock;

  typedef struct {
    int          acc;
    int          nw;
    logic [15:0] addr;
    logic [7:0]  data;
  } txn_t;

  txn_t       q[$];
  txn_t       cur;
  bit         cur_v = 1'b0;
  int         cyc = 0;
  int         next_free = 0;
  int         vectors = 0;
  int         errors = 0;
  logic [7:0] last_data = 8'h00;
  logic [7:0] nd = 8'h00;
  int         nnw = 0;
  bit         mon_en = 1'b0;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [15:0] act,
                       input logic [15:0] exp);
    vectors++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cyc=%0d actual=%h expected=%h", name, cyc, act, exp);
    end
  endtask

  task automatic check_rst(input string tag);
    check({tag, "_p0_out"}, 16'(p0_out), 16'h00FF);
    check({tag, "_p2_out"}, 16'(p2_out), 16'h00FF);
    check({tag, "_ctl"}, 16'({ale, rd_n, p0_oe, busy, done}), 16'b01000);
    check({tag, "_data"}, 16'(data_out), 16'h0000);
  endtask

  // One clock of stimulus; the model decides whether this request is accepted.
  task automatic step(input bit req, input bit ri, input logic [7:0] ra,
                      input logic [7:0] dh, input logic [7:0] dl,
                      input logic [7:0] sfr);
    int tcc;
    @(negedge clock);
    rd_req  = req;
    use_ri  = ri;
    ri_addr = ra;
    dptr_h  = dh;
    dptr_l  = dl;
    p2_sfr  = sfr;
    if (req && cyc >= next_free) begin
      cur.acc   = cyc;
      cur.nw    = WAIT_EN ? nnw : 0;
      cur.addr  = ri ? {sfr, ra} : {dh, dl};
      cur.data  = nd;
      cur_v     = 1'b1;
      q.push_back(cur);
      next_free = cyc + A + R + 3 + cur.nw;
    end
    tcc   = cur.acc + A + R + 1;
    p0_in = 8'($urandom);
    if (cur_v && cyc == tcc + cur.nw) p0_in = cur.data;
`ifdef XDATA_WAIT_EN
    ext_wait = 1'($urandom);
    if (cur_v && cyc >= tcc && cyc < tcc + cur.nw) ext_wait = 1'b1;
    if (cur_v && cyc == tcc + cur.nw) ext_wait = 1'b0;
`endif
  endtask

  task automatic idle(input int n, input logic [7:0] sfr);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 8'h00, 8'h00, 8'h00, sfr);
  endtask

  task automatic stepr();
    nd  = 8'($urandom);
    nnw = $urandom_range(0, 4);
    step($urandom_range(0, 2) == 0, 1'($urandom), 8'($urandom),
         8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  always @(posedge clock) begin : mon
    int rel, dc;
    logic [4:0] ctl;
    logic [7:0] hi, lo;
    bit bus;
    #1;
    if (mon_en && reset) begin
      ctl = 5'b01000;
      hi  = p2_sfr;
      lo  = 8'hFF;
      bus = 1'b0;
      if (q.size() > 0) begin
        rel = cyc - q[0].acc;
        dc  = A + R + 2 + q[0].nw;
        lo  = q[0].addr[7:0];
        if (rel >= 1 && rel < dc) hi = q[0].addr[15:8];
        if (rel >= 1 && rel <= A) ctl = 5'b11110;
        else if (rel == A + 1) ctl = 5'b01110;
        else if (rel >= A + 2 && rel < dc) ctl = 5'b00010;
        else if (rel == dc) ctl = 5'b01011;
        bus = (rel >= 1 && rel <= A + 1);
        if (rel >= dc) begin
          last_data = q[0].data;
          void'(q.pop_front());
        end
      end
      check("ale_rdn_oe_busy_done", 16'({ale, rd_n, p0_oe, busy, done}),
            16'(ctl));
      check("p2_out", 16'(p2_out), 16'(hi));
      if (bus) check("p0_out", 16'(p0_out), 16'(lo));
      check("data_out", 16'(data_out), 16'(last_data));
    end
  end

  initial begin
    repeat (3) @(negedge clock);
    check_rst("por");
    reset  = 1'b1;
    mon_en = 1'b1;
    idle(2, 8'h00);

    // DPTR read of 0x1234 returning 0xA5
    nd = 8'hA5; nnw = 0;
    step(1'b1, 1'b0, 8'h00, 8'h12, 8'h34, 8'h00);
    idle(12, 8'h00);

    // @Ri read with P2 SFR supplying the high byte, then P2 tracking the SFR
    nd = 8'h3C;
    step(1'b1, 1'b1, 8'h7F, 8'hAA, 8'hBB, 8'h80);
    idle(8, 8'h80);
    idle(4, 8'h55);

    // Requests and DPTR changes while busy must be ignored
    nd = 8'h96;
    step(1'b1, 1'b0, 8'h00, 8'h12, 8'h34, 8'h00);
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 8'h00, 8'hFF, 8'hFF, 8'h00);
    idle(12, 8'h00);

    // Back-to-back reads, request held high throughout
    nd = 8'hA5;
    step(1'b1, 1'b0, 8'h00, 8'h20, 8'h01, 8'h00);
    nd = 8'h5A;
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 8'h00, 8'h20, 8'h02, 8'h00);
    idle(12, 8'h00);

    // Asynchronous reset in the middle of READ
    nd = 8'hC3;
    step(1'b1, 1'b0, 8'h00, 8'h12, 8'h34, 8'h00);
    idle(3, 8'h00);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check_rst("midread");
    q.delete();
    cur_v     = 1'b0;
    last_data = 8'h00;
    repeat (2) @(negedge clock);
    reset     = 1'b1;
    next_free = cyc + 1;
    idle(4, 8'h00);

    // Long wait-state read (only stretches when the wait feature is built in)
    nd = 8'h69; nnw = 4;
    step(1'b1, 1'b0, 8'h00, 8'h43, 8'h21, 8'h00);
    idle(14, 8'h00);

    for (int i = 0; i < 800; i++) stepr();
    idle(14, 8'h00);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

endmodule
